// File: rtl/matrix_func_sequencer.sv
// Sequences a chain of matrix function units over two 64-row ping-pong buffers:
// host load, per-stage clear/run/swap, write capture and final readback.
module matrix_func_sequencer #(
  parameter int NUM_STAGES = 5,
  parameter int DEPTH      = 64,
  parameter int WIDTH      = 25,
  parameter int CNT_W      = 7,
  parameter int TIMEOUT    = 4095
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        ld_en,
  input  logic [5:0]                  ld_addr,
  input  logic [WIDTH-1:0]            ld_data,
  input  logic [5:0]                  rd_addr,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [2:0]                  cur_stage,
  output logic                        stg_rst,
  output logic [NUM_STAGES-1:0]       stg_start,
  input  logic [NUM_STAGES-1:0]       stg_done,
  input  logic [NUM_STAGES*CNT_W-1:0] stg_cnt,
  output logic [WIDTH-1:0]            stg_line,
  input  logic [NUM_STAGES-1:0]       stg_wr_en,
  input  logic [NUM_STAGES*WIDTH-1:0] stg_wr_val
);

  localparam int AW = 6;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TMO  = TW'(TIMEOUT);
  localparam logic [2:0]    LAST = 3'(NUM_STAGES - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLR1, S_CLR2, S_RUN, S_SWAP, S_FIN} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              cur_stage_q, cur_stage_d;
  logic                    src_sel_q, src_sel_d;
  logic                    err_q, err_d;
  logic                    ovf_q, ovf_d;
  logic [AW:0]             wr_cnt_q, wr_cnt_d;
  logic [TW-1:0]           tmr_q, tmr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    stg_rst_q, stg_rst_d;
  logic [NUM_STAGES-1:0]   stg_start_q, stg_start_d;

  logic [WIDTH-1:0]        buf_a_q [DEPTH];
  logic [WIDTH-1:0]        buf_b_q [DEPTH];

  logic                    act_done, act_wr_en;
  logic [WIDTH-1:0]        act_wr_val;
  logic [CNT_W-1:0]        act_cnt;
  logic [AW-1:0]           line_addr;
  logic                    host_we, stg_we, a_we, b_we;
  logic [AW-1:0]           w_addr;
  logic [WIDTH-1:0]        w_data;

  always_comb begin
    act_done   = 1'b0;
    act_wr_en  = 1'b0;
    act_wr_val = '0;
    act_cnt    = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (cur_stage_q == 3'(i)) begin
        act_done   = stg_done[i];
        act_wr_en  = stg_wr_en[i];
        act_wr_val = stg_wr_val[i*WIDTH +: WIDTH];
        act_cnt    = stg_cnt[i*CNT_W +: CNT_W];
      end
    end
  end

  // Unit reads one row ahead of its counter; the address wraps mod 64.
  assign line_addr = AW'(act_cnt + CNT_W'(1));
  assign stg_line  = src_sel_q ? buf_b_q[line_addr] : buf_a_q[line_addr];
  assign rd_data   = src_sel_q ? buf_b_q[rd_addr] : buf_a_q[rd_addr];

  always_comb begin
    state_d     = state_q;
    cur_stage_d = cur_stage_q;
    src_sel_d   = src_sel_q;
    err_d       = err_q;
    ovf_d       = ovf_q;
    wr_cnt_d    = wr_cnt_q;
    tmr_d       = tmr_q;
    host_we     = 1'b0;
    stg_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        host_we = ld_en;
        if (start) begin
          err_d       = 1'b0;
          cur_stage_d = 3'd0;
          state_d     = S_CLR1;
        end
      end
      S_CLR1, S_CLR2: begin
        wr_cnt_d = '0;
        ovf_d    = 1'b0;
        tmr_d    = '0;
        state_d  = (state_q == S_CLR1) ? S_CLR2 : S_RUN;
      end
      S_RUN: begin
        if (act_wr_en) begin
          if (wr_cnt_q < FULL) begin
            stg_we   = 1'b1;
            wr_cnt_d = wr_cnt_q + (AW + 1)'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (act_done) begin
          state_d = S_SWAP;
        end else if (tmr_q == TMO) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_SWAP: begin
        if (wr_cnt_q != FULL || ovf_q) err_d = 1'b1;
        src_sel_d = ~src_sel_q;
        if (cur_stage_q == LAST) begin
          state_d = S_FIN;
        end else begin
          cur_stage_d = cur_stage_q + 3'd1;
          state_d     = S_CLR1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_FIN);
    stg_rst_d   = (state_d == S_CLR1) || (state_d == S_CLR2);
    stg_start_d = (state_d == S_RUN) ? (NUM_STAGES'(1) << cur_stage_d) : '0;
  end

  // Host loads land in src, unit writes in dst; both are blocked during reset.
  always_comb begin
    a_we   = rst && ((host_we && !src_sel_q) || (stg_we && src_sel_q));
    b_we   = rst && ((host_we && src_sel_q) || (stg_we && !src_sel_q));
    w_addr = host_we ? ld_addr : wr_cnt_q[AW-1:0];
    w_data = host_we ? ld_data : act_wr_val;
  end

  always_ff @(posedge clk) begin
    if (a_we) buf_a_q[w_addr] <= w_data;
    if (b_we) buf_b_q[w_addr] <= w_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cur_stage_q <= 3'd0;
      src_sel_q   <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      wr_cnt_q    <= '0;
      tmr_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stg_rst_q   <= 1'b0;
      stg_start_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_stage_q <= cur_stage_d;
      src_sel_q   <= src_sel_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      wr_cnt_q    <= wr_cnt_d;
      tmr_q       <= tmr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      stg_rst_q   <= stg_rst_d;
      stg_start_q <= stg_start_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cur_stage = cur_stage_q;
  assign stg_start = stg_start_q;
  assign stg_rst   = stg_rst_q | ~rst;

endmodule

// File: doc/matrix_func_sequencer.md
# matrix_func_sequencer

Controller that sequences a chain of matrix-encoder function units (column-parity and sibling stages) over a shared pair of 64×25-bit ping-pong row buffers. It loads an input matrix from the host and gives each unit exclusive read access to the source buffer through its `cnt_value` address. It captures the unit's `write_value` stream into the destination buffer, swaps the buffers on each unit's `donee`, and exposes the final matrix for readback. It replaces the file-driven testbench harness as the on-chip owner of unit start/reset and memory.

## Interface
Parameters:
- `NUM_STAGES`, 5: number of function units chained (1..8).
- `DEPTH`, 64: rows per matrix (fixed at 64; pointers wrap mod 64).
- `WIDTH`, 25: bits per row.
- `CNT_W`, 7: width of each unit's `cnt_value`.
- `TIMEOUT`, 4095: maximum cycles a stage may spend in RUN.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: begin a run; sampled only in IDLE.
- `ld_en` in 1: host row write into the source buffer; honoured only in IDLE.
- `ld_addr` in 6: row index for the host write.
- `ld_data` in 25: row value for the host write.
- `rd_addr` in 6: result row index.
- `rd_data` out 25: combinational read of the source buffer at `rd_addr`.
- `busy` out 1: high from the cycle after an accepted start until returning to IDLE.
- `done` out 1: one-cycle pulse on completion or abort.
- `err` out 1: sticky protocol error, cleared by the next accepted start.
- `cur_stage` out 3: index of the active stage.
- `stg_rst` out 1: active-high reset to all units.
- `stg_start` out NUM_STAGES: one-hot start to the active unit.
- `stg_done` in NUM_STAGES: unit `donee` signals.
- `stg_cnt` in NUM_STAGES*CNT_W: flattened unit `cnt_value` buses; stage k occupies bits [k*CNT_W +: CNT_W].
- `stg_line` out 25: source row `(stg_cnt[active] + 1) mod 64`, combinational.
- `stg_wr_en` in NUM_STAGES: unit write strobes.
- `stg_wr_val` in NUM_STAGES*WIDTH: flattened unit write values.

## Operation
- States: IDLE → CLR (2 cycles) → RUN → SWAP (1 cycle) → CLR for the next stage, or FIN (1 cycle) → IDLE.
- IDLE: `ld_en` writes `ld_data` to `src[ld_addr]`. Accepting `start` clears `err`, sets k=0, and goes to CLR.
- CLR: `stg_rst` is 1, all `stg_start` bits are 0, and `wr_ptr` and the timeout counter are cleared.
- RUN: `stg_start[k]` is held at 1. In each cycle with `stg_wr_en[k]` high, `dst[wr_ptr]` receives `stg_wr_val[k]` and `wr_ptr` increments. Inputs from non-active stages are ignored.
- RUN exit: a cycle with `stg_done[k]` high moves to SWAP. A write in that same cycle is accepted first.
- SWAP: sets `err` if the write count is not 64. Writes beyond 64 are dropped and set `err`; unwritten rows keep their old contents. SWAP then toggles src/dst and increments k, going to FIN if k = NUM_STAGES-1, else to CLR.
- Timeout: RUN lasting TIMEOUT cycles sets `err`, deasserts `stg_start`, skips the toggle, and goes to FIN.
- FIN: pulses `done`. The result is the current src buffer. A subsequent `start` without reload chains from that result.
- `start` and `ld_en` while busy are ignored.
- After reset the src pointer is buffer A. Buffer contents are not reset.

## Timing
- Reset values: `busy` 0, `done` 0, `err` 0, `stg_start` 0, `cur_stage` 0, `stg_rst` 1 while `rst` is low, 0 in IDLE.
- Example: `start` high in IDLE at cycle t gives `busy` = 1 and `stg_rst` = 1 at t+1 and t+2. `stg_start[0]` = 1 from t+3.
- `stg_done[k]` at cycle d gives SWAP at d+1 and next-stage CLR at d+2.
- Per-stage overhead is 4 cycles (CLR 2, SWAP 1, plus done sampling). FIN adds 1 cycle.
- `stg_line` and `rd_data` are zero-latency reads. A write and a read of the same row in the same cycle return the old data.
- Reset mid-run: all outputs return to reset values on the next edge and the FSM enters IDLE.

## Test plan
- Load rows i = i for 64 rows, NUM_STAGES = 1, unit model echoing `stg_line` after 1 cycle → rows read back as (i+1) mod 64 values in order; `done` fires once, `err` = 0.
- Five chained models, each XORing the row with 25'h1 → readback equals the load pattern XOR 25'h1 (odd number of inversions). `cur_stage` steps 0..4 and `stg_rst` pulses twice per stage.
- Unit asserts done after 63 writes → `err` = 1 at FIN and row 63 of the result retains its prior value. The next `start` clears `err`.
- Unit never asserts done → `done` pulses TIMEOUT+1 cycles after RUN entry, `err` = 1, buffers are not swapped.
- `start` and `ld_en` pulsed mid-run → ignored, buffer unchanged. Write and done asserted in the same cycle → the 64th row is stored.
- `rst` driven low during RUN of stage 2 → next edge gives `busy` = 0 and `stg_start` = 0. A fresh run then completes correctly from buffer A.
